// File: rtl/regset_port_ctrl_if.sv
// Register-set (BRAM) side bus: one write port and two synchronous read ports.
// master = controller, slave = register-set memory.
interface regset_port_ctrl_if;
    logic        rs_we;
    logic [5:0]  rs_wa;
    logic [31:0] rs_wd;
    logic        rs_wg;
    logic [5:0]  rs_ra1;
    logic [5:0]  rs_ra2;
    logic [31:0] rs_rd1;
    logic        rs_rg1;
    logic [31:0] rs_rd2;
    logic        rs_rg2;

    modport master (
        output rs_we, rs_wa, rs_wd, rs_wg, rs_ra1, rs_ra2,
        input  rs_rd1, rs_rg1, rs_rd2, rs_rg2
    );

    modport slave (
        input  rs_we, rs_wa, rs_wd, rs_wg, rs_ra1, rs_ra2,
        output rs_rd1, rs_rg1, rs_rd2, rs_rg2
    );
endinterface

// File: rtl/regset_port_ctrl.sv
// Front-end between the pipeline and the 64-entry BRAM register set: init sweep,
// stall-held read addressing, last-write bypass and x0 = 0 enforcement.
module regset_port_ctrl #(
    parameter logic [31:0] INIT_DATA   = 32'h0,
    parameter logic        INIT_GRUBBY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        wr_grubby,
    input  logic [5:0]  rd_addr1,
    input  logic [5:0]  rd_addr2,
    input  logic        stall,
    output logic        ready,
    output logic [31:0] rd_data1,
    output logic        rd_grubby1,
    output logic [31:0] rd_data2,
    output logic        rd_grubby2,
    regset_port_ctrl_if.master rs
);

    typedef enum logic {StInit, StRun} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        ready_q;
    logic [5:0]  ha1_q, ha2_q;
    logic        bv_q;
    logic [5:0]  ba_q;
    logic [31:0] bd_q;
    logic        bg_q;

    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic        wg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= 6'd0;
            ready_q <= 1'b0;
            ha1_q   <= 6'd0;
            ha2_q   <= 6'd0;
            bv_q    <= 1'b0;
            ba_q    <= 6'd0;
            bd_q    <= 32'd0;
            bg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_q | (state_q == StRun);
            if (!stall) begin
                ha1_q <= rd_addr1;
                ha2_q <= rd_addr2;
            end
            bv_q <= (state_q == StRun) & we;
            ba_q <= wa;
            bd_q <= wd;
            bg_q <= wg;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        wa      = wr_addr;
        wd      = wr_data;
        wg      = wr_grubby;
        unique case (state_q)
            StInit: begin
                we    = 1'b1;
                wa    = cnt_q;
                wd    = INIT_DATA;
                wg    = INIT_GRUBBY;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) state_d = StRun;
            end
            StRun: we = wr_en && (wr_addr != 6'd0);
            default: ;
        endcase
    end

    // Write enable is held low while reset is asserted.
    always_comb begin
        rs.rs_we  = we & ~rst;
        rs.rs_wa  = wa;
        rs.rs_wd  = wd;
        rs.rs_wg  = wg;
        rs.rs_ra1 = stall ? ha1_q : rd_addr1;
        rs.rs_ra2 = stall ? ha2_q : rd_addr2;
    end

    assign ready = ready_q;

    // BRAM returns old data on read-during-write, so the last write is forwarded.
    always_comb begin
        rd_data1   = 32'd0;
        rd_grubby1 = 1'b0;
        rd_data2   = 32'd0;
        rd_grubby2 = 1'b0;
        if (state_q == StRun && ha1_q != 6'd0) begin
            if (bv_q && ba_q == ha1_q) begin
                rd_data1   = bd_q;
                rd_grubby1 = bg_q;
            end else begin
                rd_data1   = rs.rs_rd1;
                rd_grubby1 = rs.rs_rg1;
            end
        end
        if (state_q == StRun && ha2_q != 6'd0) begin
            if (bv_q && ba_q == ha2_q) begin
                rd_data2   = bd_q;
                rd_grubby2 = bg_q;
            end else begin
                rd_data2   = rs.rs_rd2;
                rd_grubby2 = rs.rs_rg2;
            end
        end
    end

endmodule
